// File: rtl/sha256_pkg.sv
// +----------------------------------------------------------------------------+
// | sha256_pkg : shared widths, FSM encoding and SHA-256 boolean functions     |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int BLK_W  = 512;
    localparam int DIG_W  = 256;
    localparam int KC_W   = 2048;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ROUND  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_round.sv
// +----------------------------------------------------------------------------+
// | sha256_round : combinational single SHA-256 round, {a..h},K,W -> {a'..h'}  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sha256_round
    import sha256_pkg::*;
(
    input  logic [DIG_W-1:0]  state_in,
    input  logic [WORD_W-1:0] kt,
    input  logic [WORD_W-1:0] wt,
    output logic [DIG_W-1:0]  state_out
);

    word_t w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    word_t w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = state_in;

    assign w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + kt + wt;
    assign w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);

    assign state_out = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

`default_nettype wire

// File: rtl/sha256_block_engine.sv
// +----------------------------------------------------------------------------+
// | sha256_block_engine : one-round-per-cycle SHA-256 compression with chaining|
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sha256_block_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [BLK_W-1:0]  blk_data,
    input  logic              blk_first,
    input  logic              blk_last,
    input  logic [DIG_W-1:0]  iv,
    input  logic [KC_W-1:0]   k_const,
    output logic              busy,
    output logic              digest_valid,
    output logic [DIG_W-1:0]  digest
);

    localparam int RND_W = 6;

    logic [1:0]       r_state;
    logic [RND_W-1:0] r_rnd;
    logic [BLK_W-1:0] r_win;
    logic [DIG_W-1:0] r_work;
    logic [DIG_W-1:0] r_base;
    logic [DIG_W-1:0] r_h;
    logic [DIG_W-1:0] r_digest;
    logic             r_last;
    logic             r_digest_valid;

    logic             w_accept;
    logic [10:0]      w_kidx;
    word_t            w_kt;
    word_t            w_wt;
    word_t            w_wnew;
    logic [DIG_W-1:0] w_next;
    logic [DIG_W-1:0] w_sum;
    logic [DIG_W-1:0] w_init;

    assign blk_ready    = (r_state == ST_IDLE) && rst_n;
    assign w_accept     = blk_valid && blk_ready;
    assign busy         = (r_state != ST_IDLE) || w_accept;
    assign digest_valid = r_digest_valid;
    assign digest       = r_digest;
    assign w_init       = blk_first ? iv : r_h;

    // Window holds W[t..t+15] with W[t] in the top word, same layout as blk_data.
    assign w_wt   = r_win[BLK_W-1 -: WORD_W];
    assign w_wnew = small_sigma1(r_win[BLK_W-1-14*WORD_W -: WORD_W])
                  + r_win[BLK_W-1-9*WORD_W -: WORD_W]
                  + small_sigma0(r_win[BLK_W-1-1*WORD_W -: WORD_W])
                  + w_wt;

    assign w_kidx = 11'd2047 - {r_rnd, 5'd0};
    assign w_kt   = k_const[w_kidx -: WORD_W];

    sha256_round u_round (
        .state_in  (r_work),
        .kt        (w_kt),
        .wt        (w_wt),
        .state_out (w_next)
    );

    for (genvar i = 0; i < 8; i++) begin : g_sum
        assign w_sum[DIG_W-1-i*WORD_W -: WORD_W] = r_base[DIG_W-1-i*WORD_W -: WORD_W]
                                                 + r_work[DIG_W-1-i*WORD_W -: WORD_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_rnd          <= '0;
            r_win          <= '0;
            r_work         <= '0;
            r_base         <= '0;
            r_h            <= '0;
            r_digest       <= '0;
            r_last         <= 1'b0;
            r_digest_valid <= 1'b0;
        end else begin
            r_digest_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_win   <= blk_data;
                        r_base  <= w_init;
                        r_work  <= w_init;
                        r_last  <= blk_last;
                        r_rnd   <= '0;
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_work <= w_next;
                    r_win  <= {r_win[BLK_W-WORD_W-1:0], w_wnew};
                    r_rnd  <= r_rnd + RND_W'(1);
                    if (r_rnd == RND_W'(ROUNDS - 1)) begin
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_h <= w_sum;
                    if (r_last) begin
                        r_digest       <= w_sum;
                        r_digest_valid <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha256_block_engine.sv
// +----------------------------------------------------------------------------+
// | tb_sha256_block_engine : known-answer vectors plus randomized chains       |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sha256_block_engine;

    localparam logic [2047:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] IV_STD = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           blk_valid = 1'b0;
    logic           blk_ready;
    logic [511:0]   blk_data = '0;
    logic           blk_first = 1'b0;
    logic           blk_last = 1'b0;
    logic [255:0]   iv = '0;
    logic [2047:0]  k_const = '0;
    logic           busy;
    logic           digest_valid;
    logic [255:0]   digest;

    sha256_block_engine #(.ROUNDS(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_data     (blk_data),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
        .iv           (iv),
        .k_const      (k_const),
        .busy         (busy),
        .digest_valid (digest_valid),
        .digest       (digest)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    int acc_last = 0;
    logic [255:0] m_h = '0;
    logic [255:0] exp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Textbook FIPS 180-4 compression over a full 64-entry message schedule.
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    function automatic logic [255:0] model_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w[64];
        logic [31:0] v[8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
               + k_const[2047-32*t -: 32] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return res;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Monitor: every digest pulse must match the next expected digest, 66 cycles after its last block.
    always begin
        @(negedge clk);
        #1;
        if (digest_valid) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                chk("unexpected_digest_valid", 256'd1, 256'd0);
            end else begin
                chk("digest", digest, exp_q.pop_front());
                chk("digest_latency", 256'(cyc - acc_last), 256'd66);
            end
        end
        if (rst_n && blk_valid && blk_ready && blk_last) acc_last = cyc;
    end

    // Called at a falling edge; returns at a falling edge where blk_ready is high again.
    task automatic run_block(input logic [511:0] b, input bit first, input bit last,
                             input bit use_const, input logic [255:0] expc);
        int t;
        int acc;
        logic [255:0] base;
        iv = IV_STD;
        t = 0;
        while (!blk_ready && t < 300) begin @(negedge clk); t++; end
        if (!blk_ready) begin
            chk("ready_timeout", 256'd0, 256'd1);
            return;
        end
        blk_data  = b;
        blk_first = first;
        blk_last  = last;
        blk_valid = 1'b1;
        base = first ? iv : m_h;
        m_h  = model_compress(base, b);
        if (last) exp_q.push_back(use_const ? expc : m_h);
        acc = cyc;
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data  = rand_blk();
        iv        = {rand_blk()}[255:0];
        chk("busy_during_block", 256'(busy), 256'd1);
        chk("ready_low_during_block", 256'(blk_ready), 256'd0);
        t = 0;
        while (!blk_ready && t < 300) begin @(negedge clk); t++; end
        chk("ready_return_latency", 256'(cyc - acc), 256'd66);
    endtask

    typedef struct {
        logic [511:0] blk0;
        logic [511:0] blk1;
        int           nblk;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs[3];
    logic [639:0] hdr;
    logic [255:0] d2;
    int prev_acc;
    int t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{blk0: {32'h61626380, 416'b0, 64'd24}, blk1: '0, nblk: 1,
                    exp: 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
        vecs[1] = '{blk0: {32'h80000000, 480'b0}, blk1: '0, nblk: 1,
                    exp: 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
        vecs[2] = '{blk0: {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                           32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                           32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0},
                    blk1: {448'b0, 64'd448}, nblk: 2,
                    exp: 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1};

        k_const = K_TABLE;
        iv      = IV_STD;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", 256'(blk_ready), 256'd1);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_digest_valid", 256'(digest_valid), 256'd0);
        chk("reset_digest", digest, 256'd0);
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            if (vecs[i].nblk == 1) begin
                run_block(vecs[i].blk0, 1'b1, 1'b1, 1'b1, vecs[i].exp);
            end else begin
                run_block(vecs[i].blk0, 1'b1, 1'b0, 1'b0, '0);
                run_block(vecs[i].blk1, 1'b0, 1'b1, 1'b1, vecs[i].exp);
            end
        end
        @(negedge clk);
        chk("kat_pulse_count", 256'(n_pulses), 256'd3);

        // Reset at round ~30: block abandoned, no pulse.
        iv = IV_STD;
        blk_data = vecs[0].blk0; blk_first = 1'b1; blk_last = 1'b1; blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_h = '0;
        #1;
        chk("midreset_busy", 256'(busy), 256'd0);
        chk("midreset_ready", 256'(blk_ready), 256'd1);
        chk("midreset_digest", digest, 256'd0);
        repeat (80) @(negedge clk);
        chk("midreset_no_pulse", 256'(n_pulses), 256'd3);

        // Non-first block straight after reset chains from H = 0.
        run_block(rand_blk(), 1'b0, 1'b1, 1'b0, '0);
        run_block(vecs[0].blk0, 1'b1, 1'b1, 1'b1, vecs[0].exp);

        // Valid held high across three back-to-back single-block messages.
        iv = IV_STD;
        blk_first = 1'b1; blk_last = 1'b1; blk_valid = 1'b1;
        prev_acc = 0;
        for (int n = 0; n < 3; n++) begin
            t = 0;
            while (!blk_ready && t < 300) begin @(negedge clk); t++; end
            blk_data = rand_blk();
            m_h = model_compress(IV_STD, blk_data);
            exp_q.push_back(m_h);
            if (n > 0) chk("b2b_accept_spacing", 256'(cyc - prev_acc), 256'd66);
            prev_acc = cyc;
            @(negedge clk);
            chk("b2b_ready_low", 256'(blk_ready), 256'd0);
            chk("b2b_busy", 256'(busy), 256'd1);
        end
        t = 0;
        while (!blk_ready && t < 300) begin @(negedge clk); t++; end
        blk_valid = 1'b0;

        // Random multi-block messages.
        for (int m = 0; m < 5; m++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                run_block(rand_blk(), b == 0, b == nb - 1, 1'b0, '0);
            end
        end

        // Bitcoin genesis header, double SHA-256.
        hdr = {32'h01000000, 256'h0,
               256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
               32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
        run_block(hdr[639:128], 1'b1, 1'b0, 1'b0, '0);
        run_block({hdr[127:0], 8'h80, 312'b0, 64'd640}, 1'b0, 1'b1, 1'b0, '0);
        d2 = m_h;
        run_block({d2, 8'h80, 184'b0, 64'd256}, 1'b1, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("genesis_double_hash", digest,
            256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000);

        repeat (2) @(negedge clk);
        chk("all_digests_delivered", 256'(exp_q.size()), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
